// File: rtl/packet_config_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : packet_config_mc
// Purpose  : AXI4-Lite configuration and run-control block for NCH packet
//            generators. A small AXI4-Lite front end turns bus transfers into
//            single-cycle ASHI write/read requests. The handler behind it holds
//            per-channel config, start/abort strobes, sent counters and DONE
//            flags, plus a START_MASK register for simultaneous launches.
// Ports    : clk, resetn (sync, active-low)
//            packet_len/packet_count/idle_cycles/initial_value : per-channel config
//            start/abort : per-channel one-cycle strobes
//            packet_gen_busy/packet_done : per-channel generator feedback
//            S_AXI_* : AXI4-Lite slave, AW-bit address, 32-bit data
// Revision : 1.0 - initial release
// ============================================================================
module packet_config_mc #(
  parameter int          AW                  = 12,
  parameter int          NCH                 = 4,
  parameter int          LEN_W               = 16,
  parameter int          MAX_LEN             = 9600,
  parameter int          DEFAULT_PACKET_LEN  = 256,
  parameter int          DEFAULT_IDLE_CYCLES = 1,
  parameter logic [15:0] DEFAULT_INIT_VALUE  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic [NCH*LEN_W-1:0] packet_len,
  output logic [NCH*32-1:0]    packet_count,
  output logic [NCH*16-1:0]    idle_cycles,
  output logic [NCH*16-1:0]    initial_value,
  output logic [NCH-1:0]       start,
  output logic [NCH-1:0]       abort,
  input  logic [NCH-1:0]       packet_gen_busy,
  input  logic [NCH-1:0]       packet_done,
  input  logic [AW-1:0]        S_AXI_AWADDR,
  input  logic [2:0]           S_AXI_AWPROT,
  input  logic                 S_AXI_AWVALID,
  output logic                 S_AXI_AWREADY,
  input  logic [31:0]          S_AXI_WDATA,
  input  logic [3:0]           S_AXI_WSTRB,
  input  logic                 S_AXI_WVALID,
  output logic                 S_AXI_WREADY,
  output logic [1:0]           S_AXI_BRESP,
  output logic                 S_AXI_BVALID,
  input  logic                 S_AXI_BREADY,
  input  logic [AW-1:0]        S_AXI_ARADDR,
  input  logic [2:0]           S_AXI_ARPROT,
  input  logic                 S_AXI_ARVALID,
  output logic                 S_AXI_ARREADY,
  output logic [31:0]          S_AXI_RDATA,
  output logic [1:0]           S_AXI_RRESP,
  output logic                 S_AXI_RVALID,
  input  logic                 S_AXI_RREADY
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int         IW          = AW - 2;   // register index width

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} wstate_t;

  // ---------------- AXI4-Lite front end (ASHI producer) ----------------
  logic          aw_full, w_full, wr_pend, ar_full;
  logic [AW-1:0] waddr, raddr;
  logic [31:0]   wdata;
  logic          ashi_write, ashi_read, ashi_widle, ashi_ridle;
  logic [1:0]    ashi_wresp, ashi_rresp;
  logic [31:0]   ashi_rdata;
  wstate_t       state;

  assign S_AXI_AWREADY = !aw_full;
  assign S_AXI_WREADY  = !w_full;
  assign S_AXI_ARREADY = !ar_full;
  assign S_AXI_RDATA   = ashi_rdata;
  assign S_AXI_RRESP   = ashi_rresp;
  assign ashi_widle    = (state == S_IDLE) && !ashi_write;
  assign ashi_ridle    = !ashi_read;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_full <= 1'b0; w_full <= 1'b0; wr_pend <= 1'b0; ar_full <= 1'b0;
      waddr <= '0; raddr <= '0; wdata <= '0;
      ashi_write <= 1'b0; ashi_read <= 1'b0;
      S_AXI_BVALID <= 1'b0; S_AXI_BRESP <= RESP_OKAY; S_AXI_RVALID <= 1'b0;
    end else begin
      ashi_write <= 1'b0;
      ashi_read  <= 1'b0;
      if (S_AXI_AWVALID && !aw_full) begin aw_full <= 1'b1; waddr <= S_AXI_AWADDR; end
      if (S_AXI_WVALID && !w_full)   begin w_full  <= 1'b1; wdata <= S_AXI_WDATA;  end
      // Issue one ASHI write once address and data are both held.
      if (aw_full && w_full && !wr_pend) begin ashi_write <= 1'b1; wr_pend <= 1'b1; end
      // Handler back to idle: its registered response is final.
      if (wr_pend && !ashi_write && ashi_widle && !S_AXI_BVALID) begin
        S_AXI_BVALID <= 1'b1; S_AXI_BRESP <= ashi_wresp;
        aw_full <= 1'b0; w_full <= 1'b0;
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin S_AXI_BVALID <= 1'b0; wr_pend <= 1'b0; end
      if (S_AXI_ARVALID && !ar_full) begin ar_full <= 1'b1; raddr <= S_AXI_ARADDR; ashi_read <= 1'b1; end
      if (ashi_read) S_AXI_RVALID <= 1'b1;
      if (S_AXI_RVALID && S_AXI_RREADY) begin S_AXI_RVALID <= 1'b0; ar_full <= 1'b0; end
    end
  end

  // ---------------- Register handler ----------------
  logic [IW-1:0]  widx, ridx;
  logic [NCH-1:0] wsel, mstart, cnt_nz, done_flag;
  logic [1:0]     wresp_c;
  logic [31:0]    sent     [NCH];
  logic [31:0]    sent_nxt [NCH];

  assign widx = waddr[AW-1:2];
  assign ridx = raddr[AW-1:2];

  // Write decode: response plus which channel / mask bits a legal write hits.
  always_comb begin
    wsel    = '0;
    mstart  = '0;
    cnt_nz  = '0;
    wresp_c = RESP_DECERR;
    for (int c = 0; c < NCH; c++) begin
      wsel[c]     = (widx[IW-1:3] == (IW-3)'(c));
      cnt_nz[c]   = |packet_count[c*32 +: 32];
      sent_nxt[c] = (&sent[c]) ? sent[c] : sent[c] + 32'd1;
    end
    if (widx == IW'(8*NCH)) begin
      // All-or-nothing: any selected busy channel rejects the whole mask.
      if (|(wdata[NCH-1:0] & packet_gen_busy)) wresp_c = RESP_SLVERR;
      else begin
        wresp_c = RESP_OKAY;
        mstart  = wdata[NCH-1:0] & cnt_nz;
      end
    end else if (|wsel) begin
      case (widx[2:0])
        3'd0, 3'd1, 3'd2, 3'd3: begin
          if (|(wsel & packet_gen_busy))
            wresp_c = RESP_SLVERR;
          else if (widx[2:0] == 3'd1 && (wdata == '0 || wdata > 32'(MAX_LEN)))
            wresp_c = RESP_SLVERR;
          else
            wresp_c = RESP_OKAY;
        end
        3'd4:       wresp_c = RESP_OKAY;
        3'd5, 3'd6: wresp_c = RESP_SLVERR;
        default:    wresp_c = RESP_DECERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      ashi_wresp <= RESP_OKAY;
      start      <= '0;
      abort      <= '0;
      done_flag  <= '0;
      for (int c = 0; c < NCH; c++) begin
        packet_len[c*LEN_W +: LEN_W] <= LEN_W'(DEFAULT_PACKET_LEN);
        packet_count[c*32 +: 32]     <= '0;
        idle_cycles[c*16 +: 16]      <= 16'(DEFAULT_IDLE_CYCLES);
        initial_value[c*16 +: 16]    <= DEFAULT_INIT_VALUE;
        sent[c]                      <= '0;
      end
    end else begin
      start <= '0;
      abort <= '0;
      case (state)
        S_IDLE: begin
          if (ashi_write) begin
            state      <= S_RESP;
            ashi_wresp <= wresp_c;
            if (wresp_c == RESP_OKAY) begin
              start <= mstart;
              for (int c = 0; c < NCH; c++) begin
                if (wsel[c]) begin
                  case (widx[2:0])
                    3'd0: if (wdata != '0) begin
                      packet_count[c*32 +: 32] <= wdata;
                      start[c]                 <= 1'b1;
                    end
                    3'd1: packet_len[c*LEN_W +: LEN_W] <= wdata[LEN_W-1:0];
                    3'd2: idle_cycles[c*16 +: 16]      <= wdata[15:0];
                    3'd3: initial_value[c*16 +: 16]    <= wdata[15:0];
                    3'd4: abort[c]                     <= wdata[0];
                    default: ;
                  endcase
                end
              end
            end
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // Clearing happens during the strobe cycle so a coincident
      // packet_done pulse is dropped rather than counted.
      for (int c = 0; c < NCH; c++) begin
        if (start[c]) begin
          sent[c]      <= '0;
          done_flag[c] <= 1'b0;
        end else if (packet_done[c]) begin
          sent[c] <= sent_nxt[c];
          if (sent_nxt[c] == packet_count[c*32 +: 32]) done_flag[c] <= 1'b1;
        end
      end
    end
  end

  // Read path: one-cycle registered decode.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ashi_rdata <= '0;
      ashi_rresp <= RESP_OKAY;
    end else if (ashi_read) begin
      ashi_rdata <= '0;
      ashi_rresp <= (ridx == IW'(8*NCH)) ? RESP_OKAY : RESP_DECERR;
      for (int c = 0; c < NCH; c++) begin
        if (ridx[IW-1:3] == (IW-3)'(c)) begin
          ashi_rresp <= (ridx[2:0] == 3'd7) ? RESP_DECERR : RESP_OKAY;
          case (ridx[2:0])
            3'd0: ashi_rdata <= packet_count[c*32 +: 32];
            3'd1: ashi_rdata <= 32'(packet_len[c*LEN_W +: LEN_W]);
            3'd2: ashi_rdata <= 32'(idle_cycles[c*16 +: 16]);
            3'd3: ashi_rdata <= 32'(initial_value[c*16 +: 16]);
            3'd5: ashi_rdata <= {30'd0, done_flag[c], packet_gen_busy[c]};
            3'd6: ashi_rdata <= sent[c];
            default: ashi_rdata <= '0;
          endcase
        end
      end
    end
  end

  wire unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                     waddr[1:0], raddr[1:0], ashi_ridle};

endmodule
`default_nettype wire

// File: tb/tb_packet_config_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_packet_config_mc
// Purpose  : Directed self-checking bench for packet_config_mc (NCH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_config_mc;
  localparam int NCH = 4;
  localparam int LEN_W = 16;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NCH*LEN_W-1:0] packet_len;
  logic [NCH*32-1:0] packet_count;
  logic [NCH*16-1:0] idle_cycles, initial_value;
  logic [NCH-1:0] start, abort;
  logic [NCH-1:0] busy = '0;
  logic [NCH-1:0] pdone = '0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [1:0] bresp, rresp;

  int checks = 0;
  int errors = 0;
  int start_tot [NCH];
  int abort_tot [NCH];
  int pair_tot = 0;
  int s_snap [NCH];
  int a_snap [NCH];
  int p_snap;
  int reg_k [5] = '{0, 1, 2, 3, 5};
  int reg_e [5] = '{0, 256, 1, 0, 0};

  packet_config_mc dut (
    .clk(clk), .resetn(resetn),
    .packet_len(packet_len), .packet_count(packet_count),
    .idle_cycles(idle_cycles), .initial_value(initial_value),
    .start(start), .abort(abort),
    .packet_gen_busy(busy), .packet_done(pdone),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(1'b1),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(1'b1)
  );

  always #5 clk = ~clk;

  initial begin
    for (int c = 0; c < NCH; c++) begin start_tot[c] = 0; abort_tot[c] = 0; end
  end

  // Count strobe cycles mid-cycle, away from the active edge.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (start[c]) start_tot[c] <= start_tot[c] + 1;
      if (abort[c]) abort_tot[c] <= abort_tot[c] + 1;
    end
    if (start == 4'b1001) pair_tot <= pair_tot + 1;
  end

  task automatic axi_write(input int idx, input logic [31:0] data, output logic [1:0] resp);
    bit aw_acc, w_acc, aw_done, w_done;
    int t;
    @(posedge clk); #1;
    awaddr = AW'(idx * 4); wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 50) begin
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      @(posedge clk); #1; t++;
      if (aw_acc) begin awvalid = 1'b0; aw_done = 1; end
      if (w_acc)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < 50) begin @(posedge clk); #1; t++; end
    if (!bvalid) begin
      checks++; errors++;
      $display("FAIL write_timeout idx=%0d: got no BVALID, required BVALID within 50 cycles", idx);
      resp = 2'bxx;
    end else resp = bresp;
  endtask

  task automatic axi_read(input int idx, output logic [31:0] data, output logic [1:0] resp);
    bit ar_acc;
    int t;
    @(posedge clk); #1;
    araddr = AW'(idx * 4); arvalid = 1'b1; t = 0;
    while (arvalid && t < 50) begin
      ar_acc = arready;
      @(posedge clk); #1; t++;
      if (ar_acc) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 50) begin @(posedge clk); #1; t++; end
    if (!rvalid) begin
      checks++; errors++;
      $display("FAIL read_timeout idx=%0d: got no RVALID, required RVALID within 50 cycles", idx);
      data = 'x; resp = 2'bxx;
    end else begin data = rdata; resp = rresp; end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    int ch;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (packet_len !== {4{16'd256}} || idle_cycles !== {4{16'd1}}) begin
      errors++; $display("FAIL reset_cfg: got len=%h idle=%h, required len=%h idle=%h",
                         packet_len, idle_cycles, {4{16'd256}}, {4{16'd1}}); end
    checks++; if (packet_count !== '0 || initial_value !== '0 || start !== '0 || abort !== '0) begin
      errors++; $display("FAIL reset_zero: got cnt=%h init=%h start=%b abort=%b, required all 0",
                         packet_count, initial_value, start, abort); end
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ch = (i == 0) ? 0 : NCH - 1;
      for (int k = 0; k < 5; k++) begin
        axi_read(8*ch + reg_k[k], d, r);
        checks++; if (d !== 32'(reg_e[k]) || r !== 2'b00) begin
          errors++; $display("FAIL reset_read ch%0d+%0d: got %0d/resp %0d, required %0d/resp 0",
                             ch, reg_k[k], d, r, reg_e[k]); end
      end
    end
  endtask

  task automatic test_len_range();
    logic [31:0] d; logic [1:0] r;
    axi_write(9, 32'd9601, r);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL len_9601_resp: got %0d, required 2", r); end
    axi_read(9, d, r);
    checks++; if (d !== 32'd256 || r !== 2'b00) begin errors++; $display("FAIL len_kept: got %0d/%0d, required 256/0", d, r); end
    axi_write(9, 32'd9600, r);
    checks++; if (r !== 2'b00 || packet_len[31:16] !== 16'd9600) begin
      errors++; $display("FAIL len_9600: got resp %0d len %0d, required 0/9600", r, packet_len[31:16]); end
    axi_write(9, 32'd0, r);
    checks++; if (r !== 2'b10 || packet_len[31:16] !== 16'd9600) begin
      errors++; $display("FAIL len_zero: got resp %0d len %0d, required 2/9600", r, packet_len[31:16]); end
  endtask

  task automatic test_run_ch2();
    logic [31:0] d; logic [1:0] r;
    s_snap = start_tot;
    axi_write(16, 32'd3, r);
    checks++; if (r !== 2'b00 || start_tot[2] - s_snap[2] != 1 || start_tot[0] != s_snap[0] ||
                  start_tot[1] != s_snap[1] || start_tot[3] != s_snap[3]) begin
      errors++; $display("FAIL ch2_start: got resp %0d ch2 strobe cycles %0d, required 0/1 (others 0)",
                         r, start_tot[2] - s_snap[2]); end
    checks++; if (packet_count[95:64] !== 32'd3) begin
      errors++; $display("FAIL ch2_count: got %0d, required 3", packet_count[95:64]); end
    busy[2] = 1'b1;
    axi_write(18, 32'd5, r);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL busy_write_resp: got %0d, required 2", r); end
    axi_read(18, d, r);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL busy_idle_kept: got %0d, required 1", d); end
    axi_read(21, d, r);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL ch2_status_busy: got %0d, required 1", d); end
    repeat (3) begin
      @(posedge clk); #1; pdone[2] = 1'b1;
      @(posedge clk); #1; pdone[2] = 1'b0;
    end
    axi_read(22, d, r);
    checks++; if (d !== 32'd3 || r !== 2'b00) begin errors++; $display("FAIL ch2_sent: got %0d/%0d, required 3/0", d, r); end
    axi_read(21, d, r);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL ch2_status_done: got %0d, required 3", d); end
    busy[2] = 1'b0;
    axi_read(21, d, r);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL ch2_status_idle: got %0d, required 2", d); end
  endtask

  task automatic test_start_mask();
    logic [31:0] d; logic [1:0] r;
    axi_write(0, 32'd2, r);
    axi_write(24, 32'd7, r);
    s_snap = start_tot; p_snap = pair_tot;
    axi_write(32, 32'h9, r);
    checks++; if (r !== 2'b00 || pair_tot - p_snap != 1 || start_tot[0] - s_snap[0] != 1 ||
                  start_tot[3] - s_snap[3] != 1 || start_tot[1] != s_snap[1] || start_tot[2] != s_snap[2]) begin
      errors++; $display("FAIL mask_start: got resp %0d joint cycles %0d s0 %0d s3 %0d, required 0/1/1/1",
                         r, pair_tot - p_snap, start_tot[0] - s_snap[0], start_tot[3] - s_snap[3]); end
    busy[3] = 1'b1;
    s_snap = start_tot;
    axi_write(32, 32'h9, r);
    checks++; if (r !== 2'b10 || start_tot[0] != s_snap[0] || start_tot[3] != s_snap[3]) begin
      errors++; $display("FAIL mask_busy: got resp %0d s0 %0d s3 %0d, required 2/0/0",
                         r, start_tot[0] - s_snap[0], start_tot[3] - s_snap[3]); end
    busy[3] = 1'b0;
    s_snap = start_tot;
    axi_write(32, 32'hF0, r);
    checks++; if (r !== 2'b00 || start_tot[0] != s_snap[0] || start_tot[1] != s_snap[1] ||
                  start_tot[2] != s_snap[2] || start_tot[3] != s_snap[3]) begin
      errors++; $display("FAIL mask_high_bits: got resp %0d with strobes, required 0 and none", r); end
    axi_read(32, d, r);
    checks++; if (d !== 32'd0 || r !== 2'b00) begin errors++; $display("FAIL mask_read: got %0d/%0d, required 0/0", d, r); end
  endtask

  task automatic test_abort();
    logic [31:0] d; logic [1:0] r;
    axi_write(8, 32'd5, r);
    busy[1] = 1'b1;
    repeat (2) begin
      @(posedge clk); #1; pdone[1] = 1'b1;
      @(posedge clk); #1; pdone[1] = 1'b0;
    end
    a_snap = abort_tot;
    axi_write(12, 32'd1, r);
    checks++; if (r !== 2'b00 || abort_tot[1] - a_snap[1] != 1 || abort_tot[0] != a_snap[0] ||
                  abort_tot[2] != a_snap[2] || abort_tot[3] != a_snap[3]) begin
      errors++; $display("FAIL abort_pulse: got resp %0d ch1 cycles %0d, required 0/1", r, abort_tot[1] - a_snap[1]); end
    axi_read(14, d, r);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL abort_sent: got %0d, required 2", d); end
    axi_read(13, d, r);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL abort_status: got %0d, required 1", d); end
    busy[1] = 1'b0;
    fork
      axi_write(8, 32'd5, r);
      begin
        for (int n = 0; n < 40; n++) begin
          @(posedge clk); #1;
          if (start[1]) begin
            pdone[1] = 1'b1;
            @(posedge clk); #1;
            pdone[1] = 1'b0;
            break;
          end
        end
      end
    join
    axi_read(14, d, r);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL restart_collision: got %0d, required 0", d); end
  endtask

  task automatic test_decode();
    logic [31:0] d; logic [1:0] r;
    axi_read(7, d, r);
    checks++; if (r !== 2'b11) begin errors++; $display("FAIL rsvd_read: got %0d, required 3", r); end
    axi_read(33, d, r);
    checks++; if (r !== 2'b11) begin errors++; $display("FAIL oob_read: got %0d, required 3", r); end
    axi_write(15, 32'd1, r);
    checks++; if (r !== 2'b11) begin errors++; $display("FAIL rsvd_write: got %0d, required 3", r); end
    axi_write(5, 32'd1, r);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL status_write: got %0d, required 2", r); end
    axi_write(6, 32'd1, r);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL sent_write: got %0d, required 2", r); end
    axi_read(12, d, r);
    checks++; if (d !== 32'd0 || r !== 2'b00) begin errors++; $display("FAIL control_read: got %0d/%0d, required 0/0", d, r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r;
    s_snap = start_tot;
    @(posedge clk); #1;
    awaddr = '0; wdata = 32'd9; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1; resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (start_tot[0] != s_snap[0] || bvalid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_strobe: got %0d strobes bvalid %b, required 0/0", start_tot[0] - s_snap[0], bvalid); end
    checks++; if (packet_count !== '0 || packet_len !== {4{16'd256}}) begin
      errors++; $display("FAIL reset_mid_regs: got cnt=%h len=%h, required 0/%h", packet_count, packet_len, {4{16'd256}}); end
    axi_read(9, d, r);
    checks++; if (d !== 32'd256 || r !== 2'b00) begin errors++; $display("FAIL reset_mid_read: got %0d/%0d, required 256/0", d, r); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_len_range();
    test_run_ch2();
    test_start_mask();
    test_abort();
    test_decode();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/packet_config_mc.md
# packet_config_mc

Multi-channel, parametrised configuration and run-control block for a bank of `NCH` downstream packet generators. It is an AXI4-Lite register slave built on the `axi4_lite_slave` core, using its ASHI write/read handler interface. Per channel it drives packet length, packet count, idle cycles and initial value, and issues start and abort strobes. It also tracks generator progress through per-channel sent-packet counters and completion flags. A global start-mask register launches any subset of channels on the same clock edge.

## Interface
- `AW`, 12: AXI address width in bits. Must satisfy 2^AW ≥ 4·(8·NCH+1).
- `NCH`, 4: number of channels, 1..16.
- `LEN_W`, 16: width of `packet_len`.
- `MAX_LEN`, 9600: largest legal packet length. Must fit in `LEN_W` bits.
- `DEFAULT_PACKET_LEN`, 256: reset value of each channel's `packet_len`.
- `DEFAULT_IDLE_CYCLES`, 1: reset value of each channel's `idle_cycles`.
- `DEFAULT_INIT_VALUE`, 16'h0000: reset value of each channel's `initial_value`.
- `clk`  in  1  clock; all logic on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `packet_len`  out  NCH·LEN_W  per-channel packet length. Channel c occupies slice [c·LEN_W +: LEN_W].
- `packet_count`  out  NCH·32  per-channel number of packets to send.
- `idle_cycles`  out  NCH·16  per-channel idle cycles between packets.
- `initial_value`  out  NCH·16  per-channel first data value.
- `start`  out  NCH  per-channel single-cycle start strobe.
- `abort`  out  NCH  per-channel single-cycle abort strobe.
- `packet_gen_busy`  in  NCH  per-channel generator-busy level.
- `packet_done`  in  NCH  per-channel one-cycle pulse, one per completed packet.
- `S_AXI_*`: full AXI4-Lite slave interface (AW, W, B, AR, R channels). Address width is `AW`; data width is 32.

## Operation
- Register index is byte address / 4. Channel c owns indices 8c..8c+7:
  - +0 PACKET_COUNT (RW). Writing a nonzero value loads the count and starts channel c. Writing 0 returns OKAY and changes nothing.
  - +1 PACKET_LEN (RW). Legal range 1..MAX_LEN; any other value returns SLVERR with no change.
  - +2 IDLE_CYCLES (RW). Low 16 bits are used.
  - +3 INIT_VALUE (RW). Low 16 bits are used.
  - +4 CONTROL (WO). Writing bit0=1 pulses `abort[c]`; always returns OKAY. Reads return 0.
  - +5 STATUS (RO). bit0 = `packet_gen_busy[c]`; bit1 = DONE, meaning the last run ended with sent == packet_count. Writes return SLVERR.
  - +6 PACKETS_SENT (RO). Writes return SLVERR.
  - +7 reserved. Accesses return DECERR.
- Index 8·NCH is START_MASK (WO). For every bit c that is set and belongs to an idle channel with nonzero `packet_count`, `start[c]` pulses in the same cycle.
  - If any selected channel is busy, the write returns SLVERR and no channel starts (all-or-nothing).
  - Bits ≥ NCH are ignored. Reads return 0.
- Any index above 8·NCH returns DECERR.
- A write to registers +0..+3 while `packet_gen_busy[c]`=1 returns SLVERR and changes nothing. The handshake always completes; the bus never stalls.
- Sent counter and DONE flag:
  - Starting a channel clears its PACKETS_SENT and its DONE flag.
  - Each `packet_done[c]` increments PACKETS_SENT[c], saturating at 32'hFFFFFFFF.
  - DONE[c] sets on the cycle PACKETS_SENT[c] becomes equal to `packet_count[c]`.
- Abort does not clear PACKETS_SENT; the count shows progress at the point of abort.
- Read data is returned unmasked; unused upper bits read as 0.
- Write state machine:
  - IDLE: accept an ASHI write, decode it, and register the response.
  - RESP: one cycle, then return to IDLE.
  - `ashi_widle` is high only in IDLE with no write pending.
- Read path: single-cycle decode. `ashi_ridle` = !ashi_read.

## Timing
- Reset values:
  - Config outputs take their DEFAULT_* values; `packet_count` = 0.
  - `start` = 0, `abort` = 0; all counters and DONE flags = 0.
  - Write state = IDLE; AXI outputs are held idle by the core.
- `start` and `abort` go high for exactly one cycle, on the cycle after the ASHI write is accepted. Config values are stable no later than that same edge.
- `packet_done` arriving on the same cycle as a start strobe: the start wins and the counter reads 0. The pulse is dropped.
- `packet_done` while a channel is not busy is still counted; the block does not gate on busy.
- Reset asserted mid-transaction: all state returns to reset values on the next edge, and any pending strobe is cancelled.
- Read latency is one clock from `ashi_read` to `ashi_rdata`/`ashi_rresp` being valid. A read of PACKETS_SENT returns the value before any same-cycle increment.

## Test plan
- Reset, then read the channel 0 and channel NCH-1 registers -> PACKET_LEN=256, IDLE=1, INIT=0, COUNT=0, STATUS=0, all with OKAY.
- Write ch1 PACKET_LEN=9601 -> SLVERR, value stays 256. Write 9600 -> OKAY, `packet_len[1]`=9600. Write 0 -> SLVERR.
- Write ch2 PACKET_COUNT=3 -> `start[2]` high for exactly one cycle, after which the bench holds busy high.
  - A write of IDLE=5 during busy -> SLVERR, value unchanged.
  - Three `packet_done[2]` pulses -> PACKETS_SENT=3 and DONE=1.
- With ch0 and ch3 idle and both counts nonzero, write START_MASK=4'b1001 -> `start[0]` and `start[3]` pulse in the same cycle.
  - Repeat with ch3 busy -> SLVERR and no strobes.
- Start ch1, then write CONTROL=1 -> one-cycle `abort[1]`. PACKETS_SENT keeps its pre-abort value and DONE=0.
  - Start again with `packet_done[1]` in the start cycle -> PACKETS_SENT=0.
- Access index 8c+7 and index 8·NCH+1 -> DECERR. Write to STATUS -> SLVERR. Reset asserted during a write -> no strobe, registers return to defaults.
